// File: rtl/symbol_sprite_ctrl.sv
// Chamfered-rectangle symbol sprite with frame-synchronous rotate commits.
// Optional build macro SYMBOL_SPRITE_BLINK_EN blanks the symbol 16 of every 32 frames.
module symbol_sprite_ctrl #(
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned X0          = 0,
  parameter int unsigned X1          = 30,
  parameter int unsigned Y0          = 0,
  parameter int unsigned Y1          = 60,
  parameter int unsigned NUM_FORMS   = 4,
  parameter int unsigned CORNER_STEP = 4,
  parameter logic [NUM_FORMS*24-1:0] COLORS =
      {24'h0000FF, 24'hFF00FF, 24'h00FF00, 24'hF26B0F},
  parameter int unsigned AUTO_PERIOD = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] Q_X,
  input  logic [COORD_W-1:0] Q_Y,
  input  logic               frame_start,
  input  logic               rot_req,
  input  logic               rot_dir,
  output logic               visible,
  output logic [7:0]         R,
  output logic [7:0]         G,
  output logic [7:0]         B,
  output logic [2:0]         rot_state,
  output logic               pending
);

  localparam int unsigned AW  = COORD_W + 2;
  localparam int unsigned FcW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD + 1) : 1;

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e            state_q, state_d;
  logic signed [3:0] cnt_q, cnt_d, cnt_mid;
  logic [2:0]        rot_q, rot_d, rot_up, rot_dn;
  logic [FcW-1:0]    frame_cnt_q, frame_cnt_d;
  logic              auto_hit;

  logic [AW-1:0]     qx, qy, dx, dy, chamfer;
  logic              in_box, show;
  logic [23:0]       color;

  always_comb begin
    rot_up = (rot_q == 3'(NUM_FORMS - 1)) ? 3'd0 : rot_q + 3'd1;
    rot_dn = (rot_q == 3'd0) ? 3'(NUM_FORMS - 1) : rot_q - 3'd1;

    frame_cnt_d = frame_cnt_q;
    auto_hit    = 1'b0;
    if (frame_start && (AUTO_PERIOD != 0)) begin
      if (frame_cnt_q == FcW'(AUTO_PERIOD - 1)) begin
        frame_cnt_d = '0;
        auto_hit    = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    // The commit consumes the pre-request counter; a same-cycle request lands afterwards.
    rot_d   = rot_q;
    cnt_mid = cnt_q;
    if (frame_start) begin
      if (state_q == StPending) begin
        if (!cnt_q[3]) begin
          rot_d   = rot_up;
          cnt_mid = cnt_q - 4'sd1;
        end else begin
          rot_d   = rot_dn;
          cnt_mid = cnt_q + 4'sd1;
        end
      end else if (auto_hit) begin
        rot_d = rot_up;
      end
    end

    cnt_d = cnt_mid;
    if (rot_req) begin
      if (!rot_dir && (cnt_mid != 4'sd7)) begin
        cnt_d = cnt_mid + 4'sd1;
      end else if (rot_dir && (cnt_mid != -4'sd7)) begin
        cnt_d = cnt_mid - 4'sd1;
      end
    end
    state_d = (cnt_d != 4'sd0) ? StPending : StIdle;
  end

  always_comb begin
    qx      = AW'(Q_X);
    qy      = AW'(Q_Y);
    in_box  = (qx >= AW'(X0)) && (qx <= AW'(X1)) && (qy >= AW'(Y0)) && (qy <= AW'(Y1));
    // dx/dy are only meaningful inside the box; in_box masks the wrapped values.
    dx      = ((qx - AW'(X0)) < (AW'(X1) - qx)) ? (qx - AW'(X0)) : (AW'(X1) - qx);
    dy      = ((qy - AW'(Y0)) < (AW'(Y1) - qy)) ? (qy - AW'(Y0)) : (AW'(Y1) - qy);
    chamfer = AW'(rot_q) * AW'(CORNER_STEP);
    show    = in_box && ((dx + dy) >= chamfer);
    color   = '0;
    for (int k = 0; k < int'(NUM_FORMS); k++) begin
      if (rot_q == 3'(k)) color = COLORS[(int'(NUM_FORMS) - 1 - k) * 24 +: 24];
    end
  end

`ifdef SYMBOL_SPRITE_BLINK_EN
  logic [4:0] blink_q;
  logic       show_gated;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= '0;
    end else if (frame_start) begin
      blink_q <= blink_q + 5'd1;
    end
  end

  assign show_gated = show && !blink_q[4];
`else
  logic show_gated;
  assign show_gated = show;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rot_q       <= '0;
      frame_cnt_q <= '0;
      visible     <= 1'b0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rot_q       <= rot_d;
      frame_cnt_q <= frame_cnt_d;
      visible     <= show_gated;
      {R, G, B}   <= show_gated ? color : 24'h0;
    end
  end

  assign rot_state = rot_q;
  assign pending   = (state_q == StPending);

endmodule
